// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Shared definitions for the elevator car controller.
//   NUM_FLOORS / FLOOR_W : building size and the width of a floor index
//   state_e              : status codes driven on the status output
//   dir_e                : direction the car is committed to
//   door_plan()          : departure decision taken when the door opens
// ---------------------------------------------------------------------------
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = $clog2(NUM_FLOORS);

  typedef enum logic [3:0] {
    ST_IDLE        = 4'd0,
    ST_MOVE_UP     = 4'd1,
    ST_MOVE_DOWN   = 4'd2,
    ST_ARRIVE_UP   = 4'd3,
    ST_ARRIVE_DOWN = 4'd4,
    ST_DOOR        = 4'd7
  } state_e;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  // Returns {nextup, nextdown}. The car keeps going the way it was heading
  // if anything lies that way, otherwise it reverses; an idle car prefers up.
  // The two bits are mutually exclusive by construction.
  function automatic logic [1:0] door_plan(input dir_e dir,
                                           input logic above,
                                           input logic below);
    logic [1:0] plan;
    if (dir == DIR_DOWN) begin
      plan = {~below & above, below};
    end else begin
      plan = {above, ~above & below};
    end
    return plan;
  endfunction

endpackage

// File: rtl/request_scan.sv
// ---------------------------------------------------------------------------
// request_scan
// Purely combinational view of the pending requests relative to the car.
//   floor   in  : current car floor
//   all_req in  : OR of every pending request type, one bit per floor
//   here    out : a request exists at the current floor
//   above   out : a request exists strictly above the current floor
//   below   out : a request exists strictly below the current floor
// ---------------------------------------------------------------------------
module request_scan
  import elevator_pkg::*;
(
  input  logic [FLOOR_W-1:0]    floor,
  input  logic [NUM_FLOORS-1:0] all_req,
  output logic                  here,
  output logic                  above,
  output logic                  below
);

  // Strict comparisons make "above" empty at the top floor and "below"
  // empty at the ground floor, which is what keeps the car from leaving
  // the shaft.
  always_comb begin
    here  = all_req[floor];
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (i > int'(floor)) begin
        above = above | all_req[i];
      end
      if (i < int'(floor)) begin
        below = below | all_req[i];
      end
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_scheduler
// LOOK-style car controller. Chooses a direction, times floor-to-floor travel
// and door dwell, and tracks the car floor.
//   clk          in  : system clock
//   rst          in  : asynchronous active-low reset
//   up           in  : pending hall up-calls, one bit per floor
//   down         in  : pending hall down-calls, one bit per floor
//   elevator_btn in  : pending in-car requests, one bit per floor
//   floor        out : current car floor (registered)
//   status       out : state code, 7 = door open at current floor (registered)
//   nextup       out : car will leave upward after this door cycle
//   nextdown     out : car will leave downward after this door cycle
//   door_open    out : status == 7 (registered)
// ---------------------------------------------------------------------------
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int MOVE_TICKS = 50000000,
  parameter int DOOR_TICKS = 100000000
)
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] up,
  input  logic [NUM_FLOORS-1:0] down,
  input  logic [NUM_FLOORS-1:0] elevator_btn,
  output logic [FLOOR_W-1:0]    floor,
  output logic [3:0]            status,
  output logic                  nextup,
  output logic                  nextdown,
  output logic                  door_open
);

  localparam int MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
  localparam int TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [TW-1:0]      MOVE_LAST  = TW'(MOVE_TICKS - 1);
  localparam logic [TW-1:0]      DOOR_LAST  = TW'(DOOR_TICKS - 1);

  state_e               state,      state_d;
  dir_e                 dir,        dir_d;
  logic [FLOOR_W-1:0]   floor_q,    floor_d;
  logic [TW-1:0]        timer,      timer_d;
  logic                 nextup_q,   nextup_d;
  logic                 nextdown_q, nextdown_d;
  logic                 door_open_q;

  logic [NUM_FLOORS-1:0] all_req;
  logic                  here;
  logic                  above;
  logic                  below;
  logic                  stop_up;
  logic                  stop_down;
  logic                  move_done;
  logic                  door_done;

  assign all_req = up | down | elevator_btn;

  request_scan u_scan (
    .floor   (floor_q),
    .all_req (all_req),
    .here    (here),
    .above   (above),
    .below   (below)
  );

  // On arrival the floor register already holds the new floor. A hall call
  // in the opposite direction only stops the car when nothing further on
  // is waiting, so it gets picked up on the way back instead.
  assign stop_up   = elevator_btn[floor_q] | up[floor_q]   | (down[floor_q] & ~above);
  assign stop_down = elevator_btn[floor_q] | down[floor_q] | (up[floor_q]   & ~below);

  assign move_done = (timer == MOVE_LAST);
  assign door_done = (timer == DOOR_LAST);

  // State register: everything that must survive a clock, cleared at once
  // by reset even in the middle of a move or a door cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      dir         <= DIR_NONE;
      floor_q     <= '0;
      timer       <= '0;
      nextup_q    <= 1'b0;
      nextdown_q  <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state       <= state_d;
      dir         <= dir_d;
      floor_q     <= floor_d;
      timer       <= timer_d;
      nextup_q    <= nextup_d;
      nextdown_q  <= nextdown_d;
      door_open_q <= (state_d == ST_DOOR);
    end
  end

  // Next-state logic. The timer defaults to zero so that it clears on every
  // state change; only the non-terminal counting branches advance it.
  // nextup/nextdown are decided once on the edge that enters DOOR and are
  // held until the door closes, so late requests cannot redirect the car.
  always_comb begin
    state_d    = state;
    dir_d      = dir;
    floor_d    = floor_q;
    timer_d    = '0;
    nextup_d   = nextup_q;
    nextdown_d = nextdown_q;

    case (state)
      ST_IDLE: begin
        if (here) begin
          state_d                = ST_DOOR;
          dir_d                  = DIR_NONE;
          {nextup_d, nextdown_d} = door_plan(DIR_NONE, above, below);
        end else if (above) begin
          state_d = ST_MOVE_UP;
          dir_d   = DIR_UP;
        end else if (below) begin
          state_d = ST_MOVE_DOWN;
          dir_d   = DIR_DOWN;
        end
      end

      ST_MOVE_UP: begin
        if (move_done) begin
          state_d = ST_ARRIVE_UP;
          // Saturate rather than wrap if the shaft end is ever reached.
          floor_d = (floor_q == TOP_FLOOR) ? floor_q : floor_q + FLOOR_W'(1);
        end else begin
          timer_d = timer + TW'(1);
        end
      end

      ST_MOVE_DOWN: begin
        if (move_done) begin
          state_d = ST_ARRIVE_DOWN;
          floor_d = (floor_q == '0) ? floor_q : floor_q - FLOOR_W'(1);
        end else begin
          timer_d = timer + TW'(1);
        end
      end

      ST_ARRIVE_UP: begin
        if (stop_up) begin
          state_d                = ST_DOOR;
          {nextup_d, nextdown_d} = door_plan(dir, above, below);
        end else begin
          state_d = ST_MOVE_UP;
        end
      end

      ST_ARRIVE_DOWN: begin
        if (stop_down) begin
          state_d                = ST_DOOR;
          {nextup_d, nextdown_d} = door_plan(dir, above, below);
        end else begin
          state_d = ST_MOVE_DOWN;
        end
      end

      ST_DOOR: begin
        if (door_done) begin
          if (nextup_q) begin
            state_d = ST_MOVE_UP;
            dir_d   = DIR_UP;
          end else if (nextdown_q) begin
            state_d = ST_MOVE_DOWN;
            dir_d   = DIR_DOWN;
          end else begin
            state_d = ST_IDLE;
            dir_d   = DIR_NONE;
          end
          nextup_d   = 1'b0;
          nextdown_d = 1'b0;
        end else begin
          timer_d = timer + TW'(1);
        end
      end

      default: begin
        state_d    = ST_IDLE;
        dir_d      = DIR_NONE;
        nextup_d   = 1'b0;
        nextdown_d = 1'b0;
      end
    endcase
  end

  // Outputs come straight from registers so downstream logic sees clean,
  // glitch-free values.
  always_comb begin
    floor     = floor_q;
    status    = state;
    nextup    = nextup_q;
    nextdown  = nextdown_q;
    door_open = door_open_q;
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// ---------------------------------------------------------------------------
// tb_elevator_scheduler
// Drives elevator_scheduler through a behavioural request-recording stage and
// compares every change of the car outputs against a queue of expected
// snapshots (floor, status, nextup, nextdown, door_open, cycles since the
// previous change).
// ---------------------------------------------------------------------------
module tb_elevator_scheduler;

  localparam int MOVE_T = 4;
  localparam int DOOR_T = 6;

  typedef struct {
    logic [2:0] fl;
    logic [3:0] st;
    logic       nu;
    logic       nd;
    int         dt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] up_q, down_q, btn_q;
  logic [7:0] set_up, set_down, set_btn;
  logic [7:0] clr_up, clr_down, clr_btn;
  logic       model_clr;

  logic [2:0] floor;
  logic [3:0] status;
  logic       nextup, nextdown, door_open;

  exp_t        sb[$];
  logic [9:0]  prev_snap;
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  elevator_scheduler #(.MOVE_TICKS(MOVE_T), .DOOR_TICKS(DOOR_T)) dut (
    .clk          (clk),
    .rst          (rst),
    .up           (up_q),
    .down         (down_q),
    .elevator_btn (btn_q),
    .floor        (floor),
    .status       (status),
    .nextup       (nextup),
    .nextdown     (nextdown),
    .door_open    (door_open)
  );

  // Request-recording stage: while the door is open the in-car button for
  // the floor is cleared, plus the hall call matching the departure
  // direction (both hall calls when the car has nowhere else to go).
  always_comb begin
    clr_up   = '0;
    clr_down = '0;
    clr_btn  = '0;
    if (door_open) begin
      clr_btn[floor] = 1'b1;
      if (nextup || !nextdown) clr_up[floor] = 1'b1;
      if (nextdown || !nextup) clr_down[floor] = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (model_clr) begin
      up_q   <= '0;
      down_q <= '0;
      btn_q  <= '0;
    end else begin
      up_q   <= (up_q   | set_up)   & ~clr_up;
      down_q <= (down_q | set_down) & ~clr_down;
      btn_q  <= (btn_q  | set_btn)  & ~clr_btn;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] global timeout");
  end

  function automatic logic [9:0] snap();
    return {floor, status, nextup, nextdown, door_open};
  endfunction

  function automatic void push_exp(input logic [2:0] f, input logic [3:0] s,
                                   input logic nu, input logic nd, input int dt);
    exp_t e;
    e.fl = f; e.st = s; e.nu = nu; e.nd = nd; e.dt = dt;
    sb.push_back(e);
  endfunction

  // Expected snapshots for travelling from one floor to another: an arrive
  // cycle at every floor, and a move state after each floor not stopped at.
  function automatic void push_travel(input int from, input int to);
    int step = (to > from) ? 1 : -1;
    logic [3:0] arr = (to > from) ? 4'd3 : 4'd4;
    logic [3:0] mv  = (to > from) ? 4'd1 : 4'd2;
    for (int f = from + step; f != to + step; f += step) begin
      push_exp(3'(f), arr, 1'b0, 1'b0, MOVE_T);
      if (f != to) push_exp(3'(f), mv, 1'b0, 1'b0, 1);
    end
  endfunction

  task automatic wait_change(output int dt, output bit tmo);
    dt  = 0;
    tmo = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      dt++;
      if (snap() !== prev_snap) begin
        prev_snap = snap();
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    prev_snap = snap();
  endtask

  task automatic pulse_req(input logic [7:0] u, input logic [7:0] d, input logic [7:0] b);
    set_up = u; set_down = d; set_btn = b;
    @(negedge clk);
    set_up = '0; set_down = '0; set_btn = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clr = 1'b1;
    set_up = '0; set_down = '0; set_btn = '0;
    #1 rst = 1'b0;
    #1;
    checks++;
    if (snap() !== 10'b0) begin
      fails++;
      $display("[TB] FAIL reset_async: got %b, want %b", snap(), 10'b0);
    end
    @(negedge clk);
    model_clr = 1'b0;
    set_up = 8'($urandom); set_down = 8'($urandom); set_btn = 8'($urandom) | 8'h02;
    @(negedge clk);
    set_up = '0; set_down = '0; set_btn = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (snap() !== 10'b0) begin
      fails++;
      $display("[TB] FAIL reset_held: got %b, want %b", snap(), 10'b0);
    end
    model_clr = 1'b1;
    @(negedge clk);
    model_clr = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (snap() !== 10'b0) begin
      fails++;
      $display("[TB] FAIL reset_release_idle: got %b, want %b", snap(), 10'b0);
    end
  endtask

  task automatic test_single_trip();
    exp_t e; int dt; bit tmo; int step = 0;
    do_reset();
    pulse_req(8'h00, 8'h00, 8'h08);
    push_exp(0, 1, 0, 0, 1);
    push_travel(0, 3);
    push_exp(3, 7, 0, 0, 1);
    push_exp(3, 0, 0, 0, DOOR_T);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step++;
      wait_change(dt, tmo);
      checks++;
      if (tmo) begin
        fails++; sb.delete();
        $display("[TB] FAIL single_trip step %0d: no output change, want fl=%0d st=%0d", step, e.fl, e.st);
      end else begin
        if (prev_snap !== {e.fl, e.st, e.nu, e.nd, (e.st == 4'd7)}) begin
          fails++;
          $display("[TB] FAIL single_trip step %0d: got %b, want fl=%0d st=%0d nu=%0b nd=%0b", step, prev_snap, e.fl, e.st, e.nu, e.nd);
        end
        checks++;
        if (dt != e.dt) begin
          fails++;
          $display("[TB] FAIL single_trip_timing step %0d: got %0d cycles, want %0d", step, dt, e.dt);
        end
      end
    end
  endtask

  task automatic test_pass_and_reverse();
    exp_t e; int dt; bit tmo; int step = 0;
    do_reset();
    pulse_req(8'h00, 8'h08, 8'h20);
    push_exp(0, 1, 0, 0, 1);
    push_travel(0, 5);
    push_exp(5, 7, 0, 1, 1);
    push_exp(5, 2, 0, 0, DOOR_T);
    push_travel(5, 3);
    push_exp(3, 7, 0, 0, 1);
    push_exp(3, 0, 0, 0, DOOR_T);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step++;
      wait_change(dt, tmo);
      checks++;
      if (tmo) begin
        fails++; sb.delete();
        $display("[TB] FAIL pass_reverse step %0d: no output change, want fl=%0d st=%0d", step, e.fl, e.st);
      end else begin
        if (prev_snap !== {e.fl, e.st, e.nu, e.nd, (e.st == 4'd7)}) begin
          fails++;
          $display("[TB] FAIL pass_reverse step %0d: got %b, want fl=%0d st=%0d nu=%0b nd=%0b", step, prev_snap, e.fl, e.st, e.nu, e.nd);
        end
        checks++;
        if (dt != e.dt) begin
          fails++;
          $display("[TB] FAIL pass_reverse_timing step %0d: got %0d cycles, want %0d", step, dt, e.dt);
        end
      end
    end
    checks++;
    if (down_q !== 8'h00) begin
      fails++;
      $display("[TB] FAIL pass_reverse_down_cleared: got %b, want %b", down_q, 8'h00);
    end
  endtask

  task automatic test_intermediate_upcall();
    exp_t e; int dt; bit tmo; int step = 0;
    do_reset();
    pulse_req(8'h04, 8'h00, 8'h10);
    push_exp(0, 1, 0, 0, 1);
    push_travel(0, 2);
    push_exp(2, 7, 1, 0, 1);
    push_exp(2, 1, 0, 0, DOOR_T);
    push_travel(2, 4);
    push_exp(4, 7, 0, 0, 1);
    push_exp(4, 0, 0, 0, DOOR_T);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step++;
      wait_change(dt, tmo);
      checks++;
      if (tmo) begin
        fails++; sb.delete();
        $display("[TB] FAIL upcall step %0d: no output change, want fl=%0d st=%0d", step, e.fl, e.st);
      end else begin
        if (prev_snap !== {e.fl, e.st, e.nu, e.nd, (e.st == 4'd7)}) begin
          fails++;
          $display("[TB] FAIL upcall step %0d: got %b, want fl=%0d st=%0d nu=%0b nd=%0b", step, prev_snap, e.fl, e.st, e.nu, e.nd);
        end
        checks++;
        if (dt != e.dt) begin
          fails++;
          $display("[TB] FAIL upcall_timing step %0d: got %0d cycles, want %0d", step, dt, e.dt);
        end
      end
    end
    checks++;
    if (up_q !== 8'h00) begin
      fails++;
      $display("[TB] FAIL upcall_up_cleared: got %b, want %b", up_q, 8'h00);
    end
  endtask

  task automatic test_call_here();
    exp_t e; int dt; bit tmo; int step = 0;
    do_reset();
    pulse_req(8'h01, 8'h00, 8'h00);
    push_exp(0, 7, 0, 0, 1);
    push_exp(0, 0, 0, 0, DOOR_T);
    while (sb.size() > 0) begin
      e = sb.pop_front(); step++;
      wait_change(dt, tmo);
      checks++;
      if (tmo) begin
        fails++; sb.delete();
        $display("[TB] FAIL call_here step %0d: no output change, want fl=%0d st=%0d", step, e.fl, e.st);
      end else begin
        if (prev_snap !== {e.fl, e.st, e.nu, e.nd, (e.st == 4'd7)}) begin
          fails++;
          $display("[TB] FAIL call_here step %0d: got %b, want fl=%0d st=%0d nu=%0b nd=%0b", step, prev_snap, e.fl, e.st, e.nu, e.nd);
        end
        checks++;
        if (dt != e.dt) begin
          fails++;
          $display("[TB] FAIL call_here_timing step %0d: got %0d cycles, want %0d", step, dt, e.dt);
        end
      end
    end
  endtask

  task automatic test_reset_mid_move();
    exp_t e; int dt; bit tmo; int step = 0;
    do_reset();
    pulse_req(8'h00, 8'h00, 8'h20);
    for (int phase = 0; phase < 2; phase++) begin
      if (phase == 0) begin
        push_exp(0, 1, 0, 0, 1);
        push_travel(0, 2);
        push_exp(2, 1, 0, 0, 1);
      end else begin
        push_exp(0, 1, 0, 0, 1);
        push_travel(0, 5);
        push_exp(5, 7, 0, 0, 1);
        push_exp(5, 0, 0, 0, DOOR_T);
      end
      while (sb.size() > 0) begin
        e = sb.pop_front(); step++;
        wait_change(dt, tmo);
        checks++;
        if (tmo) begin
          fails++; sb.delete();
          $display("[TB] FAIL mid_move_reset step %0d: no output change, want fl=%0d st=%0d", step, e.fl, e.st);
        end else begin
          if (prev_snap !== {e.fl, e.st, e.nu, e.nd, (e.st == 4'd7)}) begin
            fails++;
            $display("[TB] FAIL mid_move_reset step %0d: got %b, want fl=%0d st=%0d nu=%0b nd=%0b", step, prev_snap, e.fl, e.st, e.nu, e.nd);
          end
          checks++;
          if (dt != e.dt) begin
            fails++;
            $display("[TB] FAIL mid_move_reset_timing step %0d: got %0d cycles, want %0d", step, dt, e.dt);
          end
        end
      end
      if (phase == 0) begin
        #2 rst = 1'b0;
        #1;
        checks++;
        if (snap() !== 10'b0) begin
          fails++;
          $display("[TB] FAIL mid_move_reset_async: got %b, want %b", snap(), 10'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        prev_snap = snap();
      end
    end
    checks++;
    if (btn_q !== 8'h00) begin
      fails++;
      $display("[TB] FAIL mid_move_reset_btn_cleared: got %b, want %b", btn_q, 8'h00);
    end
  endtask

  initial begin
    $display("[TB] elevator_scheduler bench start");
    test_reset();
    test_single_trip();
    test_pass_and_reverse();
    test_intermediate_upcall();
    test_call_here();
    test_reset_mid_move();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Consumes the latched request vectors (up, down, elevator_btn) from the request-recording stage.
- Runs a LOOK-style car controller: decides direction, times floor-to-floor travel and door dwell, and tracks the current floor.
- Produces floor, status, nextup and nextdown. The request stage uses these to clear serviced requests: status 7 means the door is open at the current floor.

Parameters:
- NUM_FLOORS, 8, number of floors; fixes request vector width and floor index range 0..7.
- MOVE_TICKS, 50000000, clk cycles spent in a MOVE state per floor; minimum 1.
- DOOR_TICKS, 100000000, clk cycles status stays 7 per stop; minimum 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous active-low reset.
- up  input  8  pending up-call per floor.
- down  input  8  pending down-call per floor.
- elevator_btn  input  8  pending in-car floor request per floor.
- floor  output  3  current car floor, registered.
- status  output  4  FSM state code, registered.
- nextup  output  1  car leaves upward after the current door cycle.
- nextdown  output  1  car leaves downward after the current door cycle.
- door_open  output  1  equals (status==7), registered.

Behaviour:
- Reset is asynchronous and active-low. While rst=0: floor=0, status=0, nextup=0, nextdown=0, door_open=0, timer=0, dir=NONE. This holds even mid-move or mid-door; there is no partial-floor recovery.
- Combinational helpers:
  - all = up|down|elevator_btn.
  - here = all[floor].
  - above = |all[7:floor+1], forced 0 at floor 7.
  - below = |all[floor-1:0], forced 0 at floor 0.
- Status codes: 0 IDLE, 1 MOVE_UP, 2 MOVE_DOWN, 3 ARRIVE_UP, 4 ARRIVE_DOWN, 7 DOOR. Other codes are unreachable and recover to IDLE.
- IDLE:
  - If here: go to DOOR, dir=NONE.
  - Else if above: go to MOVE_UP, dir=UP.
  - Else if below: go to MOVE_DOWN, dir=DOWN.
  - Else stay.
  - Priority is here > above > below.
- MOVE_UP / MOVE_DOWN: timer counts 0..MOVE_TICKS-1. On the terminal count, floor increments/decrements, timer clears, and the FSM goes to ARRIVE_UP/ARRIVE_DOWN. A floor costs MOVE_TICKS+1 cycles including the arrive cycle.
- ARRIVE_UP (uses the already-updated floor):
  - Stop if elevator_btn[floor] | up[floor] | (down[floor] & ~above), then go to DOOR.
  - Otherwise go back to MOVE_UP.
- ARRIVE_DOWN: mirror of ARRIVE_UP; stop if elevator_btn[floor] | down[floor] | (up[floor] & ~below).
- DOOR entry computes nextup/nextdown once, registered on the entering edge:
  - dir=UP: nextup=above; nextdown=~above & below.
  - dir=DOWN: nextdown=below; nextup=~below & above.
  - dir=NONE: nextup=above; nextdown=~above & below.
  - nextup and nextdown are never both 1. Both are held constant for the whole DOOR period.
- DOOR: timer counts DOOR_TICKS cycles. On expiry:
  - nextup: go to MOVE_UP, dir=UP.
  - nextdown: go to MOVE_DOWN, dir=DOWN.
  - Neither: go to IDLE, dir=NONE.
  - In all cases nextup/nextdown clear.
- Requests arriving during DOOR do not change nextup/nextdown. They are handled at exit or in IDLE.
- Requests are only ever cleared at the current floor (or by reset), so a latched nextup/nextdown target always still exists at exit.
- Boundaries:
  - Floor never wraps; above/below masking prevents moving past 0 or 7.
  - A request for the current floor while moving does not stop the car until the next ARRIVE evaluation.
- Timer width is $clog2(max(MOVE_TICKS,DOOR_TICKS)). The timer clears on every state change.

Decomposition:
- Package elevator_pkg holds NUM_FLOORS, status codes (ST_IDLE=0, ST_MOVE_UP=1, ST_MOVE_DOWN=2, ST_ARRIVE_UP=3, ST_ARRIVE_DOWN=4, ST_DOOR=7) and dir encoding (NONE/UP/DOWN).
- One natural sub-module: request_scan, combinational, floor + all -> here/above/below.
- Timer and FSM stay in elevator_scheduler.

Test Plan:
- Bench setup: MOVE_TICKS=4, DOOR_TICKS=6. The bench instantiates the request-recording stage so serviced requests clear.
1. Reset: hold rst=0 with random request inputs -> floor=0, status=0, nextup=nextdown=0 with no clock edge needed. Release -> status stays 0 while no requests.
2. Single trip: at floor 0 set elevator_btn[3] -> status 1 next edge; floor 1,2,3 at 5-cycle spacing; status 7 at floor 3 for exactly 6 cycles with nextup=nextdown=0; then status 0.
3. Pass-through and reversal: floor 0, set elevator_btn[5] and down[3] -> floor 3 passed without status 7. Stop at 5 with nextdown=1. Move down, stop at 3 with nextup=nextdown=0, down[3] cleared.
4. Intermediate up-call: floor 0, set up[2] and elevator_btn[4] -> stop at 2 with nextup=1 (up[2] cleared, down untouched), then continue to 4.
5. Request at current floor while idle: floor 0, up[0]=1 -> status 7 without moving, nextup=nextdown=0.
6. Reset mid-move: rst=0 during MOVE_UP at floor 2 -> floor=0, status=0 asynchronously. After release, pending requests replay from floor 0.
